// File: rtl/rv_pkg.sv
// Shared RV64 fetch types and constants.
// Imported by the fetch interface, buffer and stage.
package rv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int INSN_BYTES = 4;

  localparam logic [ILEN-1:0] NOP_INSN =
    32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_e;

  // Wraps modulo 2^XLEN by construction.
  function automatic logic [XLEN-1:0] pc_next(
    input logic [XLEN-1:0] pc
  );
    return pc + XLEN'(INSN_BYTES);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode handshake bundle.
// Master is the fetch stage, slave is decode.
interface instruction_fetch_if;
  import rv_pkg::*;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            if_fault;

  modport master (
    output if_valid,
    output if_pc,
    output if_instr,
    output if_fault,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_pc,
    input  if_instr,
    input  if_fault,
    output if_ready
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous fetch buffer with flush.
// Full buffer accepts a push when it pops.
module ifetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  last;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush &
                   (~full | do_pop);

  // Empty buffer shows the last popped entry.
  assign dout = empty ? last : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr];
      end
      unique case (1'b1)
        do_push & ~do_pop:
          count <= count + 1'b1;
        do_pop & ~do_push:
          count <= count - 1'b1;
        default:
          count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, redirect, buffer to decode.
// IFETCH_MISALIGN_TRAP_EN halts on misaligned redirect.
module instruction_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  instruction_fetch_if.master dec
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target;
  logic            halted;
  logic            room;
  logic            push;
  logic            pop;
  logic            empty;
  logic [CW-1:0]   count;
  fetch_entry_t    din;
  fetch_entry_t    head;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic fault;
  logic misalign;

  assign target   = redirect_pc;
  assign misalign = |redirect_pc[1:0];
  assign dec.if_fault = fault;
`else
  assign target = redirect_pc &
                  ~XLEN'(INSN_BYTES - 1);
  assign dec.if_fault = 1'b0;
`endif

  assign halted = (state == HALT);
  assign room   = (count < CW'(FIFO_DEPTH));
  assign pop    = dec.if_valid & dec.if_ready;
  assign push   = ~redirect_valid & ~halted &
                  (room | pop);

  assign imem_addr = fetch_pc;
  assign din.pc    = fetch_pc;
  assign din.instr = imem_instr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fault    <= 1'b0;
`endif
    end else if (redirect_valid) begin
      fetch_pc <= target;
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (misalign) begin
        state <= HALT;
        fault <= 1'b1;
      end
`endif
    end else if (push) begin
      fetch_pc <= pc_next(fetch_pc);
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .dout  (head),
    .count (count),
    .empty (empty)
  );

  assign dec.if_valid = ~empty;
  assign dec.if_pc    = head.pc;
  assign dec.if_instr = head.instr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch.
// Queue model of the fetch buffer checked every cycle.
module tb_instruction_fetch;

  localparam int DEPTH = 2;
  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  instruction_fetch_if dif ();

  instruction_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(
    input logic [63:0] a
  );
    return a[31:0] ^ a[63:32] ^ 32'hA5A5_0013;
  endfunction

  assign imem_instr = memword(imem_addr);

  int vectors = 0;
  int miss = 0;
  bit chk_en = 0;

  task automatic chk(
    input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  logic [63:0] q[$];
  logic [63:0] mpc;
  bit          mhalt;
  bit          mfault;

  always @(posedge clk) begin : model
    logic [63:0] tgt;
    logic [63:0] dropped;
    if (!rst_n) begin
      q.delete();
      mpc = RST_PC;
      mhalt = 0;
      mfault = 0;
    end else if (redirect_valid) begin
      q.delete();
      tgt = redirect_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) begin
        mhalt = 1;
        mfault = 1;
      end
`else
      tgt[1:0] = 2'b00;
`endif
      mpc = tgt;
    end else begin
      if (dif.if_ready && q.size() != 0)
        dropped = q.pop_front();
      if (!mhalt && q.size() < DEPTH) begin
        q.push_back(mpc);
        mpc = mpc + 64'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", dif.if_valid, q.size() != 0);
      chk("fault", dif.if_fault, mfault);
      chk("imem_addr", imem_addr, mpc);
      if (q.size() != 0) begin
        chk("if_pc", dif.if_pc, q[0]);
        chk("if_instr", dif.if_instr,
            memword(q[0]));
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", dif.if_valid, 0);
    chk("rst_pc", dif.if_pc, 0);
    chk("rst_instr", dif.if_instr, 0);
    chk("rst_fault", dif.if_fault, 0);
    chk("rst_addr", imem_addr, RST_PC);
  endtask

  initial begin
    logic [63:0] exp_pc [4];
    logic [31:0] exp_in [4];
    exp_pc = '{64'h0, 64'h4, 64'h8, 64'hC};
    exp_in = '{32'hA5A5_0013, 32'hA5A5_0017,
               32'hA5A5_001B, 32'hA5A5_001F};

    rst_n = 0;
    redirect_valid = 0;
    redirect_pc = '0;
    dif.if_ready = 1;
    step(2);
    chk_en = 1;
    chk_reset_vals();

    // 1: streaming from reset
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_valid", dif.if_valid, 1);
      chk("t1_pc", dif.if_pc, exp_pc[k]);
      chk("t1_instr", dif.if_instr, exp_in[k]);
    end

    // 2: stall fills buffer, then drain
    rst_n = 0;
    dif.if_ready = 0;
    step(2);
    rst_n = 1;
    step(5);
    chk("t2_addr", imem_addr, 64'h8);
    chk("t2_pc0", dif.if_pc, 64'h0);
    dif.if_ready = 1;
    step();
    chk("t2_pc1", dif.if_pc, 64'h4);
    step();
    chk("t2_pc2", dif.if_pc, 64'h8);

    // 3: redirect while full
    dif.if_ready = 0;
    step(2);
    dif.if_ready = 1;
    redirect_valid = 1;
    redirect_pc = 64'h100;
    step();
    redirect_valid = 0;
    chk("t3_gap", dif.if_valid, 0);
    step();
    chk("t3_pc0", dif.if_pc, 64'h100);
    chk("t3_in0", dif.if_instr, 32'hA5A5_0113);
    step();
    chk("t3_pc1", dif.if_pc, 64'h104);

    // 4: back-to-back redirects
    redirect_valid = 1;
    redirect_pc = 64'h200;
    step();
    redirect_pc = 64'h300;
    step();
    redirect_valid = 0;
    chk("t4_gap", dif.if_valid, 0);
    step();
    chk("t4_pc", dif.if_pc, 64'h300);

    // 5: PC wrap
    redirect_valid = 1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 0;
    step();
    chk("t5_pc0", dif.if_pc,
        64'hFFFF_FFFF_FFFF_FFFC);
    chk("t5_in0", dif.if_instr, 32'hA5A5_0010);
    step();
    chk("t5_pc1", dif.if_pc, 64'h0);

    // 6: misaligned redirect
    redirect_valid = 1;
    redirect_pc = 64'h102;
    step();
    redirect_valid = 0;
    step();
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("t6_fault", dif.if_fault, 1);
    chk("t6_valid", dif.if_valid, 0);
    step(3);
    chk("t6_hold", dif.if_valid, 0);
`else
    chk("t6_pc", dif.if_pc, 64'h100);
    chk("t6_fault", dif.if_fault, 0);
    step(3);
`endif

    // mid-stream reset
    rst_n = 0;
    step();
    chk_reset_vals();
    rst_n = 1;
    step(4);
    chk("post_pc", dif.if_pc, 64'hC);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miss);
    $finish;
  end

endmodule
